// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types, the position-to-data-bit map and a reference
//               Hamming(12,8) encoder for the shared SEC decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    typedef logic [11:0] codeword_t;
    typedef logic [7:0]  data_t;
    typedef logic [3:0]  syndrome_t;

    // Hamming position (1-based) holding data bit dk at index k-1
    localparam int c_data_pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    // Reference encoder: place data bits, then fill each parity position
    // 2^b with the XOR of every position whose index has bit b set.
    function automatic codeword_t hamming_enc(input data_t d);
        codeword_t cw;
        logic      p;
        cw = '0;
        for (int k = 0; k < 8; k++) begin
            cw[c_data_pos[k] - 1] = d[k];
        end
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 12; pos++) begin
                if ((pos & (1 << b)) != 0) p = p ^ cw[pos - 1];
            end
            cw[(1 << b) - 1] = p;
        end
        return cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_dec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_dec_ctrl_if
// Description : Requester, consumer and status signals of the shared decoder.
//               slave = decoder side, master = requester/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface hamming_dec_ctrl_if #(
    parameter int CNT_W = 16
);
    import hamming_pkg::*;

    logic             vld_a;
    codeword_t        cw_a;
    logic             rdy_a;
    logic             vld_b;
    codeword_t        cw_b;
    logic             rdy_b;
    logic             corr_en;
    logic             clr_cnt;
    logic             out_vld;
    logic             out_rdy;
    data_t            out_data;
    logic             out_src;
    syndrome_t        out_syn;
    logic             out_corr;
    logic             out_uncorr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    modport slave (
        input  vld_a, cw_a, vld_b, cw_b, corr_en, clr_cnt, out_rdy,
        output rdy_a, rdy_b, out_vld, out_data, out_src, out_syn,
               out_corr, out_uncorr, corr_cnt, uncorr_cnt
    );

    modport master (
        output vld_a, cw_a, vld_b, cw_b, corr_en, clr_cnt, out_rdy,
        input  rdy_a, rdy_b, out_vld, out_data, out_src, out_syn,
               out_corr, out_uncorr, corr_cnt, uncorr_cnt
    );

endinterface
`default_nettype wire

// File: rtl/hamming_dec_core.sv
`default_nettype none
// ============================================================================
// Module      : hamming_dec_core
// Description : Combinational Hamming(12,8) single-error-correcting decoder.
//               Syndrome 1..12 names the bad position; 13..15 is invalid and
//               the data bits are passed through untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_dec_core
    import hamming_pkg::*;
(
    input  wire codeword_t i_cw,
    input  wire logic      i_corr_en,
    output data_t          o_data,
    output syndrome_t      o_syn,
    output logic           o_corr,
    output logic           o_uncorr
);

    syndrome_t w_syn;
    codeword_t w_cw_fix;

    // Syndrome, optional single-bit flip, then data extraction
    always_comb begin
        w_syn    = '0;
        w_cw_fix = i_cw;
        o_data   = '0;
        for (int b = 0; b < 4; b++) begin
            for (int pos = 1; pos <= 12; pos++) begin
                if ((pos & (1 << b)) != 0) w_syn[b] = w_syn[b] ^ i_cw[pos - 1];
            end
        end
        // Flipping a parity position is harmless: only data bits are extracted
        for (int pos = 1; pos <= 12; pos++) begin
            if (i_corr_en && (w_syn == 4'(pos))) w_cw_fix[pos - 1] = ~i_cw[pos - 1];
        end
        for (int k = 0; k < 8; k++) begin
            o_data[k] = w_cw_fix[c_data_pos[k] - 1];
        end
        o_syn    = w_syn;
        o_corr   = i_corr_en && (w_syn != 4'd0) && (w_syn <= 4'd12);
        o_uncorr = (w_syn >= 4'd13);
    end

endmodule
`default_nettype wire

// File: rtl/hamming_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hamming_dec_ctrl
// Description : Round-robin shares one Hamming(12,8) decoder between two
//               requesters behind a two-stage valid/ready pipeline, with
//               saturating corrected/uncorrectable word counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_dec_ctrl
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hamming_dec_ctrl_if.slave bus
);

    logic             r_prio;      // 0: A preferred on contention, 1: B
    logic             r_s1_vld;
    codeword_t        r_s1_cw;
    logic             r_s1_src;
    logic             r_out_vld;
    data_t            r_out_data;
    logic             r_out_src;
    syndrome_t        r_out_syn;
    logic             r_out_corr;
    logic             r_out_uncorr;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    logic      w_s2_en;
    logic      w_s1_free;
    logic      w_gnt_a;
    logic      w_gnt_b;
    logic      w_acc_a;
    logic      w_acc_b;
    logic      w_hs;
    data_t     w_dec_data;
    syndrome_t w_dec_syn;
    logic      w_dec_corr;
    logic      w_dec_uncorr;

    // Handshake and grant logic; a single grant per cycle
    assign w_s2_en   = ~r_out_vld | bus.out_rdy;
    assign w_s1_free = ~r_s1_vld | w_s2_en;
    assign w_gnt_a   = bus.vld_a & (~bus.vld_b | ~r_prio);
    assign w_gnt_b   = bus.vld_b & (~bus.vld_a |  r_prio);
    assign w_acc_a   = w_s1_free & w_gnt_a;
    assign w_acc_b   = w_s1_free & w_gnt_b;
    assign w_hs      = r_out_vld & bus.out_rdy;

    assign bus.rdy_a      = w_acc_a;
    assign bus.rdy_b      = w_acc_b;
    assign bus.out_vld    = r_out_vld;
    assign bus.out_data   = r_out_data;
    assign bus.out_src    = r_out_src;
    assign bus.out_syn    = r_out_syn;
    assign bus.out_corr   = r_out_corr;
    assign bus.out_uncorr = r_out_uncorr;
    assign bus.corr_cnt   = r_corr_cnt;
    assign bus.uncorr_cnt = r_uncorr_cnt;

    hamming_dec_core u_core (
        .i_cw      (r_s1_cw),
        .i_corr_en (bus.corr_en),
        .o_data    (w_dec_data),
        .o_syn     (w_dec_syn),
        .o_corr    (w_dec_corr),
        .o_uncorr  (w_dec_uncorr)
    );

    // Round-robin pointer: the requester just served loses the next tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_acc_a | w_acc_b) begin
            r_prio <= w_acc_a;
        end
    end

    // Stage 1: capture the granted codeword, empty when it moves on
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_cw  <= '0;
            r_s1_src <= 1'b0;
        end else if (w_acc_a | w_acc_b) begin
            r_s1_vld <= 1'b1;
            r_s1_cw  <= w_acc_a ? bus.cw_a : bus.cw_b;
            r_s1_src <= w_acc_b;
        end else if (w_s2_en) begin
            r_s1_vld <= 1'b0;
        end
    end

    // Stage 2: decoded output registers, frozen while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= 1'b0;
            r_out_syn    <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (w_s2_en) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_data   <= w_dec_data;
                r_out_src    <= r_s1_src;
                r_out_syn    <= w_dec_syn;
                r_out_corr   <= w_dec_corr;
                r_out_uncorr <= w_dec_uncorr;
            end
        end
    end

    // Saturating counters bumped on delivered words; a clear beats a bump
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_hs) begin
            if (r_out_corr && (r_corr_cnt != {CNT_W{1'b1}})) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
            if (r_out_uncorr && (r_uncorr_cnt != {CNT_W{1'b1}})) begin
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_dec_ctrl
// Description : Directed self-checking bench for hamming_dec_ctrl (CNT_W=2
//               so counter saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_dec_ctrl;
    import hamming_pkg::*;

    localparam int CNT_W = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic       grant_q [$];
    logic [8:0] out_q   [$];
    int         stall_acc;
    int         unstable;
    int         dual;

    hamming_dec_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hamming_dec_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait for its grant, then wait for it at the output
    task automatic send_one(input logic src, input codeword_t cw,
                            output data_t d, output syndrome_t syn, output logic c,
                            output logic u, output logic s, output bit to);
        int n;
        to = 1'b0;
        if (!src) begin bus.vld_a = 1'b1; bus.cw_a = cw; end
        else      begin bus.vld_b = 1'b1; bus.cw_b = cw; end
        #1;
        n = 0;
        while (!(src ? bus.rdy_b : bus.rdy_a) && n < 10) begin tick(); n++; end
        if (n >= 10) to = 1'b1;
        tick();
        bus.vld_a = 1'b0;
        bus.vld_b = 1'b0;
        n = 0;
        while (!bus.out_vld && n < 10) begin tick(); n++; end
        if (n >= 10) to = 1'b1;
        d = bus.out_data; syn = bus.out_syn; c = bus.out_corr;
        u = bus.out_uncorr; s = bus.out_src;
    endtask

    // Both requesters stream n words each; consumer stalls for the first
    // 'stall' cycles. Grants and delivered {src,data} are logged.
    task automatic stream(input int n, input int stall, input data_t base_a,
                          input data_t base_b, output bit to);
        int         ia, ib, cyc;
        logic [8:0] held;
        bit         have_held;
        grant_q.delete(); out_q.delete();
        stall_acc = 0; unstable = 0; dual = 0;
        ia = 0; ib = 0; cyc = 0; have_held = 1'b0; held = '0;
        while (out_q.size() < 2 * n && cyc < 60) begin
            bus.vld_a   = (ia < n);
            bus.cw_a    = hamming_enc(base_a + data_t'(ia));
            bus.vld_b   = (ib < n);
            bus.cw_b    = hamming_enc(base_b + data_t'(ib));
            bus.out_rdy = (cyc >= stall);
            #1;
            if (bus.out_vld && bus.out_rdy) out_q.push_back({bus.out_src, bus.out_data});
            if (bus.out_vld && !bus.out_rdy) begin
                if (!have_held) begin held = {bus.out_src, bus.out_data}; have_held = 1'b1; end
                else if (held !== {bus.out_src, bus.out_data}) unstable++;
            end
            if (bus.rdy_a && bus.rdy_b) dual++;
            if (bus.rdy_a && bus.vld_a) begin
                grant_q.push_back(1'b0); ia++;
                if (cyc < stall) stall_acc++;
            end else if (bus.rdy_b && bus.vld_b) begin
                grant_q.push_back(1'b1); ib++;
                if (cyc < stall) stall_acc++;
            end
            tick();
            cyc++;
        end
        to = (out_q.size() < 2 * n);
        bus.vld_a = 1'b0; bus.vld_b = 1'b0; bus.out_rdy = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.vld_a = 1'b0; bus.cw_a = '0; bus.vld_b = 1'b0; bus.cw_b = '0;
        bus.corr_en = 1'b1; bus.clr_cnt = 1'b0; bus.out_rdy = 1'b1;
        repeat (3) tick();
        checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        checks++; if (bus.corr_cnt !== 2'd0) begin failures++; $display("FAIL reset_corr_cnt: got %0d want 0", bus.corr_cnt); end
        checks++; if (bus.uncorr_cnt !== 2'd0) begin failures++; $display("FAIL reset_uncorr_cnt: got %0d want 0", bus.uncorr_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    // Clean word from A: visible two edges after being presented
    task automatic test_clean();
        bus.vld_a = 1'b1; bus.cw_a = 12'hA27;
        #1;
        checks++; if (bus.rdy_a !== 1'b1) begin failures++; $display("FAIL clean_rdy_a: got %b want 1", bus.rdy_a); end
        tick();
        bus.vld_a = 1'b0;
        checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL clean_early_vld: got %b want 0", bus.out_vld); end
        tick();
        checks++; if (bus.out_vld !== 1'b1) begin failures++; $display("FAIL clean_vld: got %b want 1", bus.out_vld); end
        checks++; if (bus.out_data !== 8'hA5) begin failures++; $display("FAIL clean_data: got %h want a5", bus.out_data); end
        checks++; if ({bus.out_src, bus.out_syn, bus.out_corr, bus.out_uncorr} !== 7'b0)
            begin failures++; $display("FAIL clean_flags: got src=%b syn=%0d corr=%b uncorr=%b want all 0",
                  bus.out_src, bus.out_syn, bus.out_corr, bus.out_uncorr); end
        tick();
        checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL clean_dup: got out_vld %b want 0", bus.out_vld); end
    endtask

    task automatic test_correct();
        data_t d; syndrome_t syn; logic c, u, s; bit to;
        bus.corr_en = 1'b1;
        send_one(1'b0, 12'hA07, d, syn, c, u, s, to);
        checks++; if (to) begin failures++; $display("FAIL corr_timeout: got timeout want delivery"); end
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL corr_data: got %h want a5", d); end
        checks++; if (syn !== 4'd6) begin failures++; $display("FAIL corr_syn: got %0d want 6", syn); end
        checks++; if ({c, u, s} !== 3'b100) begin failures++; $display("FAIL corr_flags: got corr/uncorr/src=%b want 100", {c, u, s}); end
        tick();
        checks++; if (bus.corr_cnt !== 2'd1) begin failures++; $display("FAIL corr_cnt: got %0d want 1", bus.corr_cnt); end
        bus.corr_en = 1'b0;
        send_one(1'b0, 12'hA07, d, syn, c, u, s, to);
        checks++; if (d !== 8'hA1) begin failures++; $display("FAIL raw_data: got %h want a1", d); end
        checks++; if ({syn, c} !== {4'd6, 1'b0}) begin failures++; $display("FAIL raw_syn_corr: got syn=%0d corr=%b want 6/0", syn, c); end
        tick();
        checks++; if (bus.corr_cnt !== 2'd1) begin failures++; $display("FAIL raw_corr_cnt: got %0d want 1", bus.corr_cnt); end
        bus.corr_en = 1'b1;
    endtask

    task automatic test_uncorr();
        data_t d; syndrome_t syn; logic c, u, s; bit to;
        send_one(1'b1, 12'h226, d, syn, c, u, s, to);
        checks++; if (to) begin failures++; $display("FAIL uncorr_timeout: got timeout want delivery"); end
        checks++; if (d !== 8'h25) begin failures++; $display("FAIL uncorr_data: got %h want 25", d); end
        checks++; if (syn !== 4'd13) begin failures++; $display("FAIL uncorr_syn: got %0d want 13", syn); end
        checks++; if ({c, u, s} !== 3'b011) begin failures++; $display("FAIL uncorr_flags: got corr/uncorr/src=%b want 011", {c, u, s}); end
        tick();
        checks++; if (bus.uncorr_cnt !== 2'd1) begin failures++; $display("FAIL uncorr_cnt: got %0d want 1", bus.uncorr_cnt); end
    endtask

    // Pointer favours A here (last grant went to B)
    task automatic test_back_to_back();
        bit to;
        stream(3, 0, 8'h10, 8'h80, to);
        checks++; if (to) begin failures++; $display("FAIL b2b_timeout: got %0d outputs want 6", out_q.size()); end
        checks++; if (dual !== 0) begin failures++; $display("FAIL b2b_dual_grant: got %0d want 0", dual); end
        checks++; if (grant_q.size() !== 6) begin failures++; $display("FAIL b2b_grants: got %0d want 6", grant_q.size()); end
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            checks++; if (grant_q[i] !== 1'(i % 2)) begin failures++; $display("FAIL b2b_order[%0d]: got %b want %b", i, grant_q[i], 1'(i % 2)); end
        end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            logic [8:0] exp;
            exp = (i % 2 == 0) ? {1'b0, 8'h10 + 8'(i / 2)} : {1'b1, 8'h80 + 8'(i / 2)};
            checks++; if (out_q[i] !== exp) begin failures++; $display("FAIL b2b_out[%0d]: got %h want %h", i, out_q[i], exp); end
        end
    endtask

    task automatic test_stall();
        bit         to;
        logic [8:0] exp [4];
        exp = '{{1'b0, 8'h41}, {1'b1, 8'hC1}, {1'b0, 8'h42}, {1'b1, 8'hC2}};
        stream(2, 5, 8'h41, 8'hC1, to);
        checks++; if (to) begin failures++; $display("FAIL stall_timeout: got %0d outputs want 4", out_q.size()); end
        checks++; if (stall_acc !== 2) begin failures++; $display("FAIL stall_accepts: got %0d want 2", stall_acc); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++; if (out_q[i] !== exp[i]) begin failures++; $display("FAIL stall_out[%0d]: got %h want %h", i, out_q[i], exp[i]); end
        end
    endtask

    task automatic test_counters();
        data_t d; syndrome_t syn; logic c, u, s; bit to;
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        checks++; if ({bus.corr_cnt, bus.uncorr_cnt} !== 4'b0) begin failures++; $display("FAIL clr_idle: got %0d/%0d want 0/0", bus.corr_cnt, bus.uncorr_cnt); end
        for (int i = 0; i < 5; i++) begin
            send_one(1'b0, hamming_enc(8'h3C + 8'(i)) ^ 12'h004, d, syn, c, u, s, to);
            tick();
            if (i == 1) begin
                checks++; if (bus.corr_cnt !== 2'd2) begin failures++; $display("FAIL cnt_inc: got %0d want 2", bus.corr_cnt); end
            end
        end
        checks++; if (bus.corr_cnt !== 2'd3) begin failures++; $display("FAIL cnt_sat: got %0d want 3", bus.corr_cnt); end
        checks++; if (bus.uncorr_cnt !== 2'd0) begin failures++; $display("FAIL cnt_uncorr_idle: got %0d want 0", bus.uncorr_cnt); end
        send_one(1'b0, hamming_enc(8'h77) ^ 12'h100, d, syn, c, u, s, to);
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        checks++; if (bus.corr_cnt !== 2'd0) begin failures++; $display("FAIL clr_wins: got %0d want 0", bus.corr_cnt); end
        send_one(1'b0, hamming_enc(8'h5A) ^ 12'h800, d, syn, c, u, s, to);
        tick();
        checks++; if (bus.corr_cnt !== 2'd1) begin failures++; $display("FAIL cnt_after_clr: got %0d want 1", bus.corr_cnt); end
    endtask

    // Reset while a word is held at the output and another sits in stage 1
    task automatic test_reset_stall();
        data_t d; syndrome_t syn; logic c, u, s; bit to;
        int seen;
        bus.out_rdy = 1'b0;
        send_one(1'b0, hamming_enc(8'h99) ^ 12'h040, d, syn, c, u, s, to);
        bus.vld_b = 1'b1; bus.cw_b = hamming_enc(8'h66);
        tick();
        bus.vld_b = 1'b0;
        checks++; if (bus.out_vld !== 1'b1 || bus.out_data !== 8'h99) begin failures++; $display("FAIL stall_hold: got vld=%b data=%h want 1/99", bus.out_vld, bus.out_data); end
        rst_n = 1'b0;
        tick();
        checks++; if ({bus.out_vld, bus.out_data, bus.out_syn, bus.out_corr} !== 14'b0) begin failures++; $display("FAIL rst_mid_out: got vld=%b data=%h syn=%0d corr=%b want 0", bus.out_vld, bus.out_data, bus.out_syn, bus.out_corr); end
        checks++; if (bus.corr_cnt !== 2'd0) begin failures++; $display("FAIL rst_mid_cnt: got %0d want 0", bus.corr_cnt); end
        rst_n = 1'b1;
        bus.out_rdy = 1'b1;
        seen = 0;
        repeat (4) begin tick(); if (bus.out_vld) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_discard: got %0d stale outputs want 0", seen); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_clean();
        test_correct();
        test_uncorr();
        test_back_to_back();
        test_stall();
        test_counters();
        test_reset_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
